fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's async FIFO among N_REQ producers in the write-clock domain.
- Grants one requester at a time for a burst of up to BURST_MAX beats, or until that requester's last beat.
- Forwards beats only when the FIFO is not full.
- Prefixes each written word with the source ID so the read side can demultiplex.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..8)
- DATA_WIDTH, 8, payload width per requester
- BURST_MAX, 4, max beats per grant (≥1)
- IDLE_TIMEOUT, 8, cycles a granted requester may hold the grant with req_valid low before forced release (≥1)
- ID_W, log2(N_REQ), derived, source-ID width

Ports:
- clk  in  1  write-domain clock (drives FIFO wr_clk)
- rst_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_WIDTH  packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  N_REQ  final beat of requester's packet
- req_ready  out  N_REQ  beat accepted when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  ID_W+DATA_WIDTH  {grant_id, payload}
- grant_id  out  ID_W  currently granted requester
- busy  out  1  high in GRANT state

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, idle_cnt=0.
  - All outputs low/zero.
  - Reset mid-burst abandons the burst; no further write is issued.
- FSM states: IDLE, GRANT.
- IDLE:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid: winner = first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Register winner into grant_id, clear beat_cnt and idle_cnt, go to GRANT.
  - Arbitration costs exactly 1 cycle; first beat is written no earlier than the cycle after the request is seen.
- GRANT, combinational outputs:
  - req_ready[grant_id] = ~fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & ~fifo_full.
  - fifo_wr_data = {grant_id, req_data[grant_id]}.
- Beat accepted (fifo_wr_en=1):
  - beat_cnt++ and idle_cnt=0.
  - If req_last[grant_id] or beat_cnt==BURST_MAX-1: go to IDLE and set rr_ptr=grant_id+1 (mod N_REQ).
- fifo_full=1: hold state. No beat is counted and idle_cnt does not advance, so backpressure never forces release.
- req_valid[grant_id]=0 and fifo_full=0:
  - idle_cnt++.
  - When idle_cnt reaches IDLE_TIMEOUT-1, go to IDLE and set rr_ptr=grant_id+1.
- Boundary conditions:
  - A burst truncated by BURST_MAX resumes only after a new round-robin win; other requesters are served first.
  - A requester granted with no other requesters pending is re-granted after one bubble cycle. A bubble cycle is mandatory between grants.
  - Requesters must hold valid/data/last stable until accepted; the arbiter does not check this.
  - fifo_full must not depend combinationally on fifo_wr_en (no loop). fifo_full asserted in the same cycle as valid blocks the write.
  - beat_cnt width is clog2(BURST_MAX)+1 with no wrap inside a burst. rr_ptr wraps modulo N_REQ.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum (IDLE, GRANT)
  - ID_W derivation function (clog2)
  - default BURST_MAX and IDLE_TIMEOUT constants
- Sub-module rr_pick:
  - Purely combinational: req vector + rr_ptr → winner index + any_req.
  - Reused by the read-side demux scheduler.

Test Plan:
- Single requester: req 2 valid with 3 beats, last on beat 3, fifo_full=0 → grant_id=2 one cycle after valid; beats written on cycles 2,3,4 with fifo_wr_data={2'd2,payload}; back to IDLE; rr_ptr=3.
- Round-robin fairness: all 4 requesters continuously valid, last never set, BURST_MAX=4 → grant order 0,1,2,3,0 with 4 beats each and 1 bubble between grants; 16 writes in 20 cycles.
- Backpressure: fifo_full high for 5 cycles during beat 2 of requester 1 → fifo_wr_en=0 and req_ready[1]=0 for those cycles; no timeout; beat 2 written the cycle full drops; beat count unaffected.
- Idle timeout: requester 3 granted then drops valid with IDLE_TIMEOUT=8 → released after 8 cycles; requester 0 (pending) granted next cycle.
- Reset mid-burst: rst_n low for 1 cycle while requester 1 is on beat 2 → next cycle busy=0, fifo_wr_en=0, req_ready=0, rr_ptr=0; re-arbitration picks the lowest-index pending requester.
- Simultaneous last and BURST_MAX: last asserted on beat 4 with BURST_MAX=4 → single release, one IDLE cycle, no extra write.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter and its read-side peers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_BURST_MAX    = 4;
    localparam int unsigned DEF_IDLE_TIMEOUT = 8;

    // Source-ID width; a single requester still gets one ID bit.
    function automatic int unsigned id_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Counter width able to hold max_val without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle; master is the arbiter, slave is the producers/FIFO side.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic                        fifo_full;
    logic                        fifo_wr_en;
    logic [ID_W+DATA_WIDTH-1:0]  fifo_wr_data;
    logic [ID_W-1:0]             grant_id;
    logic                        busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner_c,
    output logic             any_req_c
);

    // N_REQ is a power of two, so ID_W-bit addition wraps modulo N_REQ.
    always_comb begin
        winner_c  = rr_ptr;
        any_req_c = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!any_req_c && req[rr_ptr + ID_W'(k)]) begin
                winner_c  = rr_ptr + ID_W'(k);
                any_req_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among N_REQ producers;
// each written word carries the source ID in its upper bits.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BURST_MAX    = DEF_BURST_MAX,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.master  bus
);

    localparam int unsigned ID_W   = id_width(N_REQ);
    localparam int unsigned BEAT_W = cnt_width(BURST_MAX);
    localparam int unsigned IDLE_W = cnt_width(IDLE_TIMEOUT);

    arb_state_t              state_q, state_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;

    logic [ID_W-1:0]         winner_c;
    logic                    any_req_c;
    logic [N_REQ-1:0]        ready_c;
    logic                    wr_en_c;
    logic [ID_W+DATA_WIDTH-1:0] wr_data_c;
    logic                    sel_valid_c;
    logic                    sel_last_c;
    logic [DATA_WIDTH-1:0]   sel_data_c;
    logic [DATA_WIDTH-1:0]   data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_valid_c = bus.req_valid[grant_q];
    assign sel_last_c  = bus.req_last[grant_q];
    assign sel_data_c  = data_arr[grant_q];

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner_c  (winner_c),
        .any_req_c (any_req_c)
    );

    // Next-state and write-port decode; backpressure freezes both counters.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        beat_d    = beat_q;
        idle_d    = idle_q;
        ready_c   = '0;
        wr_en_c   = 1'b0;
        wr_data_c = '0;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    grant_d = winner_c;
                    beat_d  = '0;
                    idle_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ready_c[grant_q] = ~bus.fifo_full;
                wr_en_c          = sel_valid_c & ~bus.fifo_full;
                wr_data_c        = {grant_q, sel_data_c};
                if (wr_en_c) begin
                    beat_d = beat_q + BEAT_W'(1);
                    idle_d = '0;
                    if (sel_last_c || (beat_q == BEAT_W'(BURST_MAX - 1))) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q + ID_W'(1);
                    end
                end else if (!bus.fifo_full) begin
                    idle_d = idle_q + IDLE_W'(1);
                    if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q + ID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle must never emit a write, even mid-burst.
        if (!rst_n) begin
            ready_c   = '0;
            wr_en_c   = 1'b0;
            wr_data_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            idle_q   <= idle_d;
        end
    end

    assign bus.req_ready    = ready_c;
    assign bus.fifo_wr_en   = wr_en_c;
    assign bus.fifo_wr_data = wr_data_c;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .N_REQ        (N),
        .DATA_WIDTH   (DW),
        .BURST_MAX    (BM),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;

    // Model: who owns the port (-1 = nobody), who scans first next time, progress of the grant.
    int owner = -1;
    int prio  = 0;
    int beats = 0;
    int idles = 0;
    int m_gid = 0;
    int grant_log[$];

    logic [N-1:0]  v, l, acc;
    logic [DW-1:0] d [N];
    logic          full;

    task automatic drive();
        bus.req_valid = v;
        bus.req_last  = l;
        bus.fifo_full = full;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = d[i];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, compare outputs against the model, advance the model across the edge.
    task automatic cycle();
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [31:0]  e_data;
        drive();
        #1;
        e_ready = '0;
        e_wr    = 1'b0;
        e_data  = '0;
        if (rst_n && owner >= 0) begin
            if (!full) e_ready[owner] = 1'b1;
            e_wr   = v[owner] && !full;
            e_data = (owner << DW) | 32'(d[owner]);
        end
        chk("busy",       32'(bus.busy),       32'(owner >= 0));
        chk("grant_id",   32'(bus.grant_id),   32'(m_gid));
        chk("req_ready",  32'(bus.req_ready),  32'(e_ready));
        chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
        if (e_wr) chk("fifo_wr_data", 32'(bus.fifo_wr_data), e_data);
        acc = e_ready & v;
        if (bus.fifo_wr_en === 1'b1) n_wr++;

        if (!rst_n) begin
            owner = -1; prio = 0; m_gid = 0; beats = 0; idles = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (prio + k) % N;
                if (owner < 0 && v[c]) owner = c;
            end
            if (owner >= 0) begin
                m_gid = owner; beats = 0; idles = 0;
                grant_log.push_back(owner);
            end
        end else if (e_wr) begin
            beats++;
            idles = 0;
            if (l[owner] || beats == BM) begin
                prio  = (owner + 1) % N;
                owner = -1;
            end
        end else if (!full) begin
            idles++;
            if (idles == TO) begin
                prio  = (owner + 1) % N;
                owner = -1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int cnt;
        int rem [N];
        int gap [N];

        rst_n = 1'b0;
        v = '0; l = '0; full = 1'b0; acc = '0;
        for (int i = 0; i < N; i++) begin d[i] = '0; rem[i] = 0; gap[i] = 0; end
        drive();
        repeat (2) @(negedge clk);

        // Reset state
        cycle();
        chk("rst_wr_data", 32'(bus.fifo_wr_data), 32'h0);
        chk("rst_ready",   32'(bus.req_ready),    32'h0);
        rst_n = 1'b1;

        // Single requester, 3-beat packet
        v[2] = 1'b1; d[2] = 8'hA0;
        cycle();
        chk("t1_grant", 32'(bus.grant_id), 32'd2);
        w0 = n_wr;
        cycle(); d[2] = 8'hA1;
        cycle(); d[2] = 8'hA2; l[2] = 1'b1;
        cycle(); v = '0; l = '0;
        chk("t1_writes", 32'(n_wr - w0), 32'd3);
        chk("t1_idle",   32'(bus.busy),  32'd0);
        // Pointer now at 3: requester 3 beats requester 0
        v[0] = 1'b1; v[3] = 1'b1; l[3] = 1'b1; d[3] = 8'h3C; d[0] = 8'h05;
        cycle();
        chk("t1_rr_ptr", 32'(bus.grant_id), 32'd3);
        cycle();
        v[3] = 1'b0; l[3] = 1'b0;

        // Round-robin fairness, all requesters streaming
        v = '1; l = '0;
        d[1] = 8'h11; d[2] = 8'h22; d[3] = 8'h33;
        grant_log.delete();
        w0 = n_wr;
        repeat (20) cycle();
        chk("t2_writes", 32'(n_wr - w0), 32'd16);
        chk("t2_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_order", 32'(grant_log[i]), 32'(i));
        cycle();
        chk("t2_wrap", 32'(bus.grant_id), 32'd0);
        l[0] = 1'b1;
        cycle();
        v = '0; l = '0;

        // Backpressure during beat 2 of requester 1
        v[1] = 1'b1; d[1] = 8'h51;
        w0 = n_wr;
        cycle();
        cycle(); d[1] = 8'h52;
        full = 1'b1;
        repeat (5) begin
            drive(); #1;
            chk("t3_full_ready", 32'(bus.req_ready[1]), 32'd0);
            cycle();
        end
        chk("t3_held_writes", 32'(n_wr - w0), 32'd1);
        chk("t3_no_release",  32'(bus.busy),  32'd1);
        full = 1'b0;
        drive(); #1;
        chk("t3_resume", 32'(bus.fifo_wr_en), 32'd1);
        cycle(); d[1] = 8'h53;
        cycle(); d[1] = 8'h54; l[1] = 1'b1;
        cycle(); v = '0; l = '0;
        chk("t3_writes", 32'(n_wr - w0), 32'd4);

        // Idle timeout on requester 3 with requester 0 pending
        v[3] = 1'b1; v[0] = 1'b1; d[3] = 8'h3A; d[0] = 8'h0A; l[0] = 1'b1;
        cycle();
        chk("t4_grant", 32'(bus.grant_id), 32'd3);
        v[3] = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 20) begin
            cycle();
            cnt++;
        end
        chk("t4_timeout", 32'(cnt), 32'd8);
        cycle();
        chk("t4_next", 32'(bus.grant_id), 32'd0);
        cycle();
        v = '0; l = '0;

        // Reset mid-burst
        v[1] = 1'b1; d[1] = 8'h61; v[3] = 1'b1; d[3] = 8'h63;
        cycle();
        chk("t5_grant", 32'(bus.grant_id), 32'd1);
        cycle(); d[1] = 8'h62;
        rst_n = 1'b0; v[0] = 1'b1; d[0] = 8'h60;
        drive(); #1;
        chk("t5_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        cycle();
        rst_n = 1'b1;
        drive(); #1;
        chk("t5_busy",  32'(bus.busy),       32'd0);
        chk("t5_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("t5_ready", 32'(bus.req_ready),  32'd0);
        cycle();
        chk("t5_rearb", 32'(bus.grant_id), 32'd0);
        rst_n = 1'b0; v = '0; l = '0;
        cycle();
        rst_n = 1'b1;

        // Last coincides with the burst limit
        v[2] = 1'b1; d[2] = 8'h71;
        cycle();
        w0 = n_wr;
        for (int b = 1; b <= 4; b++) begin
            l[2] = (b == 4);
            cycle();
            d[2] = d[2] + 8'd1;
        end
        l[2] = 1'b0;
        chk("t6_writes", 32'(n_wr - w0), 32'd4);
        chk("t6_release", 32'(bus.busy), 32'd0);
        drive(); #1;
        chk("t6_bubble", 32'(bus.fifo_wr_en), 32'd0);
        cycle();
        chk("t6_no_extra", 32'(n_wr - w0), 32'd4);
        chk("t6_regrant",  32'(bus.busy),  32'd1);
        rst_n = 1'b0; v = '0;
        cycle();
        rst_n = 1'b1;

        // Randomized producers: packets, gaps long enough to time out, random FIFO full
        repeat (3000) begin
            full = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !acc[i])) begin
                    if (acc[i]) begin
                        rem[i]--;
                        if ($urandom_range(0, 3) == 0) gap[i] = $urandom_range(1, 12);
                    end
                    if (rem[i] == 0 && gap[i] == 0 && $urandom_range(0, 5) == 0)
                        rem[i] = $urandom_range(1, 7);
                    if (rem[i] > 0 && gap[i] == 0) begin
                        v[i] = 1'b1;
                        d[i] = DW'($urandom);
                        l[i] = (rem[i] == 1);
                    end else begin
                        v[i] = 1'b0;
                        l[i] = 1'b0;
                        if (gap[i] > 0) gap[i]--;
                    end
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
